// File: rtl/noc_local_endpoint.sv
// ---------------------------------------------------------------------------
// NocLocalEndpoint (module noc_local_endpoint)
//
// Network interface sitting on the LOCAL port of a mesh router node.
//
// TX side: the tile hands over a destination and a payload. The endpoint
// builds a flit {payload, NODE_ADDRESS, dst} in a holding register and
// presents it to the router until the router is not full on a rising edge.
// A new request can be loaded on the same edge that the previous flit
// leaves, so a steady stream moves one flit per cycle.
//
// RX side: the router's local output has no backpressure. Flits addressed
// to this node go into a small show-ahead FIFO. Flits for other nodes, and
// flits that arrive while the FIFO is full and not being popped, are dropped
// and counted.
//
// Flit layout: [2:0] dst, [5:3] src, [DATA_WIDTH-1:6] payload.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   tx_valid/tx_ready    tile send handshake
//   tx_dst, tx_payload   destination and payload of the send request
//   NI_DATA_OUT          flit to router LOCAL_DATA_IN
//   NI_DATA_VALID_OUT    to router LOCAL_DATA_VALID_IN
//   NI_FULL_IN           from router LOCAL_FULL_OUT
//   NI_DATA_IN           from router LOCAL_DATA_OUT
//   NI_DATA_VALID_IN     from router LOCAL_DATA_VALID_OUT
//   rx_valid/rx_ready    tile receive handshake (head of RX FIFO)
//   rx_src, rx_payload   fields of the RX FIFO head entry
//   tx_cnt               flits injected, saturating at 255
//   rx_cnt               flits stored in the RX FIFO, saturating at 255
//   drop_cnt             flits dropped (overflow or misaddressed), saturating
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module noc_local_endpoint #(
  parameter logic [2:0]  NODE_ADDRESS = 3'b1,
  parameter int unsigned RX_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [2:0]               tx_dst,
  input  logic [`DATA_WIDTH-7:0]   tx_payload,
  output logic [`DATA_WIDTH-1:0]   NI_DATA_OUT,
  output logic                     NI_DATA_VALID_OUT,
  input  logic                     NI_FULL_IN,
  input  logic [`DATA_WIDTH-1:0]   NI_DATA_IN,
  input  logic                     NI_DATA_VALID_IN,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [2:0]               rx_src,
  output logic [`DATA_WIDTH-7:0]   rx_payload,
  output logic [7:0]               tx_cnt,
  output logic [7:0]               rx_cnt,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RX_DEPTH);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // FIFO entries keep only src and payload; dst is known to be ours.
  localparam int unsigned EW = DW - 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } txState_e;

  // -------------------------------------------------------------------------
  // TX path
  // -------------------------------------------------------------------------
  txState_e        state_q, state_d;
  logic [DW-1:0]   flit_q, flit_d;
  logic            txLoad;
  logic            txXfer;

  // A flit leaves whenever we are presenting one and the router has room.
  assign txXfer = (state_q == SEND) && !NI_FULL_IN;
  assign txLoad = tx_valid && tx_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. While SEND is blocked by the router everything holds;
  // once the flit leaves we stay in SEND only if a new request is loaded.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (!NI_FULL_IN) begin
          state_d = tx_valid ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. tx_ready follows NI_FULL_IN combinationally so a blocked
  // flit is never overwritten while it is still being presented.
  always_comb begin
    tx_ready          = 1'b0;
    NI_DATA_VALID_OUT = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
      end
      SEND: begin
        tx_ready          = !NI_FULL_IN;
        NI_DATA_VALID_OUT = 1'b1;
      end
      default: begin
        tx_ready          = 1'b0;
        NI_DATA_VALID_OUT = 1'b0;
      end
    endcase
  end

  // Holding register: only changes on an accepted request, which can only
  // happen when nothing is being presented or the current flit is leaving.
  always_comb begin
    flit_d = flit_q;
    if (txLoad) begin
      flit_d = {tx_payload, NODE_ADDRESS, tx_dst};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_q <= '0;
    end else begin
      flit_q <= flit_d;
    end
  end

  assign NI_DATA_OUT = flit_q;

  // -------------------------------------------------------------------------
  // RX path
  // -------------------------------------------------------------------------
  logic [EW-1:0]   mem_q [RX_DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rxAddrOk;
  logic            rxFull;
  logic            rxPop;
  logic            rxPush;
  logic            rxDrop;
  logic [EW-1:0]   rxHead;

  // A pop needs a non-empty FIFO, so a push+pop on an empty FIFO is just a
  // push. A full FIFO that is popped this cycle still accepts a write.
  assign rxAddrOk = (NI_DATA_IN[2:0] == NODE_ADDRESS);
  assign rxFull   = (count_q == DEPTH_C);
  assign rx_valid = (count_q != '0);
  assign rxPop    = rx_valid && rx_ready;
  assign rxPush   = NI_DATA_VALID_IN && rxAddrOk && (!rxFull || rxPop);
  assign rxDrop   = NI_DATA_VALID_IN && !rxPush;

  // Pointer and occupancy next-state. Pointers wrap naturally because the
  // depth is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (rxPush) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (rxPop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    unique case ({rxPush, rxPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array needs no reset: the occupancy counter decides what is
  // valid, and reset empties it.
  always_ff @(posedge clk) begin
    if (rxPush) begin
      mem_q[wrPtr_q] <= NI_DATA_IN[DW-1:3];
    end
  end

  // Show-ahead: the head entry is always on the outputs.
  assign rxHead     = mem_q[rdPtr_q];
  assign rx_src     = rxHead[2:0];
  assign rx_payload = rxHead[EW-1:3];

  // -------------------------------------------------------------------------
  // Statistics counters, all saturating at 255.
  // -------------------------------------------------------------------------
  logic [7:0] txCnt_q, rxCnt_q, dropCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txCnt_q <= '0;
    end else if (txXfer && (txCnt_q != CNT_MAX)) begin
      txCnt_q <= txCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxCnt_q <= '0;
    end else if (rxPush && (rxCnt_q != CNT_MAX)) begin
      rxCnt_q <= rxCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropCnt_q <= '0;
    end else if (rxDrop && (dropCnt_q != CNT_MAX)) begin
      dropCnt_q <= dropCnt_q + 8'd1;
    end
  end

  assign tx_cnt   = txCnt_q;
  assign rx_cnt   = rxCnt_q;
  assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_noc_local_endpoint.sv
// ---------------------------------------------------------------------------
// Testbench for noc_local_endpoint with DATA_WIDTH=16, NODE_ADDRESS=1.
// TX flits are pushed to a scoreboard queue on acceptance and popped when
// the router side sees them; RX flits are modelled the same way and popped
// when the tile reads the FIFO head.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_noc_local_endpoint;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [2:0]  tx_dst = '0;
  logic [9:0]  tx_payload = '0;
  logic [15:0] NI_DATA_OUT;
  logic        NI_DATA_VALID_OUT;
  logic        NI_FULL_IN = 1'b0;
  logic [15:0] NI_DATA_IN = '0;
  logic        NI_DATA_VALID_IN = 1'b0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [2:0]  rx_src;
  logic [9:0]  rx_payload;
  logic [7:0]  tx_cnt;
  logic [7:0]  rx_cnt;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] txExp[$];
  logic [12:0] rxExp[$];
  int expTx = 0;
  int expRx = 0;
  int expDrop = 0;

  noc_local_endpoint #(
    .NODE_ADDRESS(3'd1),
    .RX_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_dst(tx_dst),
    .tx_payload(tx_payload),
    .NI_DATA_OUT(NI_DATA_OUT),
    .NI_DATA_VALID_OUT(NI_DATA_VALID_OUT),
    .NI_FULL_IN(NI_FULL_IN),
    .NI_DATA_IN(NI_DATA_IN),
    .NI_DATA_VALID_IN(NI_DATA_VALID_IN),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_src(rx_src),
    .rx_payload(rx_payload),
    .tx_cnt(tx_cnt),
    .rx_cnt(rx_cnt),
    .drop_cnt(drop_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Builds the flit the endpoint should emit.
  function automatic logic [15:0] mkFlit(input logic [2:0] dst, input logic [2:0] src,
                                         input logic [9:0] pl);
    return {pl, src, dst};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the RX FIFO and its counters for one edge.
  task automatic rxModel(input logic vld, input logic [2:0] dst, input logic [2:0] src,
                         input logic [9:0] pl, input logic doPop);
    bit popHappens;
    bit full;
    popHappens = doPop && (rxExp.size() > 0);
    full = (rxExp.size() >= 4);
    if (popHappens) void'(rxExp.pop_front());
    if (vld) begin
      if (dst == 3'd1 && (!full || popHappens)) begin
        rxExp.push_back({src, pl});
        if (expRx < 255) expRx++;
      end else begin
        if (expDrop < 255) expDrop++;
      end
    end
  endtask

  // Drive one RX cycle from the router side and/or a tile pop.
  task automatic rxDrive(input logic vld, input logic [2:0] dst, input logic [2:0] src,
                         input logic [9:0] pl, input logic doPop);
    NI_DATA_VALID_IN = vld;
    NI_DATA_IN = {pl, src, dst};
    rx_ready = doPop;
    rxModel(vld, dst, src, pl, doPop);
    stepClk();
    NI_DATA_VALID_IN = 1'b0;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) stepClk();
    checks++; if (NI_DATA_VALID_OUT !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", NI_DATA_VALID_OUT); end
    checks++; if (NI_DATA_OUT !== 16'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0000", NI_DATA_OUT); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid got=%0b exp=0", rx_valid); end
    checks++; if ({tx_cnt, rx_cnt, drop_cnt} !== 24'h0) begin failures++; $display("[TB] FAIL reset_counters got=%h exp=000000", {tx_cnt, rx_cnt, drop_cnt}); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx_ready got=%0b exp=1", tx_ready); end
    rst_n = 1'b1;
    stepClk();
  endtask

  task automatic test_send();
    logic [15:0] exp;
    tx_dst = 3'd5; tx_payload = 10'h2A5; tx_valid = 1'b1;
    #1;
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL send_ready got=%0b exp=1", tx_ready); end
    if (tx_ready) txExp.push_back(mkFlit(3'd5, 3'd1, 10'h2A5));
    stepClk();
    tx_valid = 1'b0;
    checks++; if (NI_DATA_VALID_OUT !== 1'b1) begin failures++; $display("[TB] FAIL send_valid got=%0b exp=1", NI_DATA_VALID_OUT); end
    exp = (txExp.size() > 0) ? txExp.pop_front() : 16'hxxxx;
    checks++; if (NI_DATA_OUT !== exp) begin failures++; $display("[TB] FAIL send_data got=%h exp=%h", NI_DATA_OUT, exp); end
    checks++; if (NI_DATA_OUT !== 16'hA94D) begin failures++; $display("[TB] FAIL send_data_literal got=%h exp=a94d", NI_DATA_OUT); end
    stepClk();
    expTx++;
    checks++; if (NI_DATA_VALID_OUT !== 1'b0) begin failures++; $display("[TB] FAIL send_valid_drop got=%0b exp=0", NI_DATA_VALID_OUT); end
    checks++; if (tx_cnt !== 8'(expTx)) begin failures++; $display("[TB] FAIL send_tx_cnt got=%0d exp=%0d", tx_cnt, expTx); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    tx_dst = 3'd2; tx_payload = 10'h155; tx_valid = 1'b1;
    txExp.push_back(mkFlit(3'd2, 3'd1, 10'h155));
    stepClk();
    tx_valid = 1'b0;
    NI_FULL_IN = 1'b1;
    exp = txExp.pop_front();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (NI_DATA_VALID_OUT !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid[%0d] got=%0b exp=1", i, NI_DATA_VALID_OUT); end
      checks++; if (NI_DATA_OUT !== exp) begin failures++; $display("[TB] FAIL bp_data[%0d] got=%h exp=%h", i, NI_DATA_OUT, exp); end
      checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready[%0d] got=%0b exp=0", i, tx_ready); end
      stepClk();
    end
    NI_FULL_IN = 1'b0;
    #1;
    checks++; if (NI_DATA_VALID_OUT !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_last got=%0b exp=1", NI_DATA_VALID_OUT); end
    checks++; if (NI_DATA_OUT !== exp) begin failures++; $display("[TB] FAIL bp_data_last got=%h exp=%h", NI_DATA_OUT, exp); end
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_release got=%0b exp=1", tx_ready); end
    stepClk();
    expTx++;
    checks++; if (NI_DATA_VALID_OUT !== 1'b0) begin failures++; $display("[TB] FAIL bp_valid_drop got=%0b exp=0", NI_DATA_VALID_OUT); end
    checks++; if (tx_cnt !== 8'(expTx)) begin failures++; $display("[TB] FAIL bp_tx_cnt got=%0d exp=%0d", tx_cnt, expTx); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      tx_dst = 3'(i);
      tx_payload = 10'(i * 37 + 5);
      tx_valid = 1'b1;
      txExp.push_back(mkFlit(3'(i), 3'd1, 10'(i * 37 + 5)));
      stepClk();
      if (i > 0) expTx++;
      exp = txExp.pop_front();
      checks++; if (NI_DATA_VALID_OUT !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d] got=%0b exp=1", i, NI_DATA_VALID_OUT); end
      checks++; if (NI_DATA_OUT !== exp) begin failures++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, NI_DATA_OUT, exp); end
    end
    tx_valid = 1'b0;
    stepClk();
    expTx++;
    checks++; if (NI_DATA_VALID_OUT !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid_end got=%0b exp=0", NI_DATA_VALID_OUT); end
    checks++; if (tx_cnt !== 8'(expTx)) begin failures++; $display("[TB] FAIL b2b_tx_cnt got=%0d exp=%0d", tx_cnt, expTx); end
  endtask

  task automatic test_rx_overflow();
    int rx0;
    int drop0;
    rx0 = expRx;
    drop0 = expDrop;
    for (int i = 0; i < 6; i++) begin
      rxDrive(1'b1, 3'd1, 3'd2, 10'(10'h300 + i), 1'b0);
    end
    checks++; if (rx_cnt !== 8'(rx0 + 4) || rx_cnt !== 8'(expRx)) begin failures++; $display("[TB] FAIL ovf_rx_cnt got=%0d exp=%0d", rx_cnt, rx0 + 4); end
    checks++; if (drop_cnt !== 8'(drop0 + 2) || drop_cnt !== 8'(expDrop)) begin failures++; $display("[TB] FAIL ovf_drop_cnt got=%0d exp=%0d", drop_cnt, drop0 + 2); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovf_rx_valid[%0d] got=%0b exp=1", i, rx_valid); end
      checks++; if ({rx_src, rx_payload} !== rxExp[0]) begin failures++; $display("[TB] FAIL ovf_head[%0d] got=%h exp=%h", i, {rx_src, rx_payload}, rxExp[0]); end
      rxDrive(1'b0, 3'd0, 3'd0, 10'h0, 1'b1);
    end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_empty got=%0b exp=0", rx_valid); end
  endtask

  task automatic test_misaddressed();
    int dropBefore;
    rxDrive(1'b1, 3'd3, 3'd2, 10'h3FF, 1'b0);
    checks++; if (drop_cnt !== 8'(expDrop)) begin failures++; $display("[TB] FAIL mis_drop_cnt got=%0d exp=%0d", drop_cnt, expDrop); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL mis_not_stored got=%0b exp=0", rx_valid); end
    for (int i = 0; i < 4; i++) rxDrive(1'b1, 3'd1, 3'd4, 10'(10'h040 + i), 1'b0);
    dropBefore = expDrop;
    checks++; if ({rx_src, rx_payload} !== rxExp[0]) begin failures++; $display("[TB] FAIL fullpop_head got=%h exp=%h", {rx_src, rx_payload}, rxExp[0]); end
    rxDrive(1'b1, 3'd1, 3'd5, 10'h0AA, 1'b1);
    checks++; if (drop_cnt !== 8'(dropBefore)) begin failures++; $display("[TB] FAIL fullpop_drop_cnt got=%0d exp=%0d", drop_cnt, dropBefore); end
    checks++; if (rx_cnt !== 8'(expRx)) begin failures++; $display("[TB] FAIL fullpop_rx_cnt got=%0d exp=%0d", rx_cnt, expRx); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1 || {rx_src, rx_payload} !== rxExp[0]) begin failures++; $display("[TB] FAIL fullpop_drain[%0d] got=%h exp=%h", i, {rx_src, rx_payload}, rxExp[0]); end
      rxDrive(1'b0, 3'd0, 3'd0, 10'h0, 1'b1);
    end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL fullpop_empty got=%0b exp=0", rx_valid); end
    // Push with a pop request on an empty FIFO: the entry must be kept.
    rxDrive(1'b1, 3'd1, 3'd6, 10'h123, 1'b1);
    checks++; if (rx_valid !== 1'b1 || {rx_src, rx_payload} !== 13'h1923) begin failures++; $display("[TB] FAIL emptypop_head got=%b/%h exp=1/1923", rx_valid, {rx_src, rx_payload}); end
    rxDrive(1'b0, 3'd0, 3'd0, 10'h0, 1'b1);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL emptypop_drain got=%0b exp=0", rx_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) rxDrive(1'b1, 3'd0, 3'd7, 10'(i), 1'b0);
    checks++; if (drop_cnt !== 8'd255 || drop_cnt !== 8'(expDrop)) begin failures++; $display("[TB] FAIL sat_drop_cnt got=%0d exp=255", drop_cnt); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL sat_rx_valid got=%0b exp=0", rx_valid); end
  endtask

  task automatic test_reset_mid_send();
    NI_FULL_IN = 1'b1;
    tx_dst = 3'd4; tx_payload = 10'h0F0; tx_valid = 1'b1;
    stepClk();
    tx_valid = 1'b0;
    rxDrive(1'b1, 3'd1, 3'd2, 10'h111, 1'b0);
    checks++; if (NI_DATA_VALID_OUT !== 1'b1 || rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_state got=%0b%0b exp=11", NI_DATA_VALID_OUT, rx_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (NI_DATA_VALID_OUT !== 1'b0) begin failures++; $display("[TB] FAIL async_valid got=%0b exp=0", NI_DATA_VALID_OUT); end
    checks++; if (NI_DATA_OUT !== 16'h0) begin failures++; $display("[TB] FAIL async_data got=%h exp=0000", NI_DATA_OUT); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_rx_valid got=%0b exp=0", rx_valid); end
    checks++; if ({tx_cnt, rx_cnt, drop_cnt} !== 24'h0) begin failures++; $display("[TB] FAIL async_counters got=%h exp=000000", {tx_cnt, rx_cnt, drop_cnt}); end
    txExp.delete(); rxExp.delete();
    expTx = 0; expRx = 0; expDrop = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    NI_FULL_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checks++; if (NI_DATA_VALID_OUT !== 1'b0 || tx_cnt !== 8'd0) begin failures++; $display("[TB] FAIL post_reset_quiet[%0d] got=%0b/%0d exp=0/0", i, NI_DATA_VALID_OUT, tx_cnt); end
    end
  endtask

  initial begin
    $display("[TB] starting noc_local_endpoint tests");
    test_reset();
    test_send();
    test_backpressure();
    test_back_to_back();
    test_rx_overflow();
    test_misaddressed();
    test_saturation();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
